// File: rtl/cache_wt_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// valid/ready handshakes, sequential flush and saturating hit/miss counters.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a CPU request or a flush
// LOOKUP  | compare tag of the registered request, update line on write hit
// RD_REQ  | read miss: present read request to memory
// RD_WAIT | wait for memory read data, then fill the line
// WR_REQ  | write-through: present write request to memory
// RESP    | one-cycle response strobe to the CPU
// FLUSH   | clear one valid bit per cycle across all lines
module cache_wt_dm #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 10,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req_valid,
   output logic              cpu_req_ready,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_rsp_valid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              flush,
   output logic              flush_busy,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int OFF_W = $clog2(DATA_W / 8);
   localparam int TAG_W = ADDR_W - OFF_W - INDEX_W;
   localparam int LINES = 2 ** INDEX_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_RD_REQ,
      S_RD_WAIT,
      S_WR_REQ,
      S_RESP,
      S_FLUSH
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_W-1:0]  addr_r;
   logic               we_r;
   logic [DATA_W-1:0]  wdata_r;
   logic [LINES-1:0]   valid_r;
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [DATA_W-1:0]  data_mem [LINES];
   logic [INDEX_W-1:0] flush_cnt;

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag;
   logic               hit;

   assign idx = addr_r[OFF_W+INDEX_W-1:OFF_W];
   assign tag = addr_r[ADDR_W-1:OFF_W+INDEX_W];
   assign hit = valid_r[idx] && (tag_mem[idx] == tag);

   assign cpu_req_ready = (state == S_IDLE) && !flush;
   assign cpu_rsp_valid = (state == S_RESP);
   assign mem_req_valid = (state == S_RD_REQ) || (state == S_WR_REQ);
   assign mem_we        = (state == S_WR_REQ);
   assign mem_addr      = addr_r;
   assign mem_wdata     = wdata_r;
   assign flush_busy    = (state == S_FLUSH);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (flush) state_nxt = S_FLUSH;
                    else if (cpu_req_valid) state_nxt = S_LOOKUP;
         S_LOOKUP:  if (we_r) state_nxt = S_WR_REQ;
                    else if (hit) state_nxt = S_RESP;
                    else state_nxt = S_RD_REQ;
         S_RD_REQ:  if (mem_req_ready) state_nxt = S_RD_WAIT;
         S_RD_WAIT: if (mem_rsp_valid) state_nxt = S_RESP;
         S_WR_REQ:  if (mem_req_ready) state_nxt = S_RESP;
         S_RESP:    state_nxt = S_IDLE;
         S_FLUSH:   if (flush_cnt == '1) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         addr_r     <= '0;
         we_r       <= 1'b0;
         wdata_r    <= '0;
         cpu_rdata  <= '0;
         valid_r    <= '0;
         flush_cnt  <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               flush_cnt <= '0;
               if (!flush && cpu_req_valid) begin
                  addr_r  <= cpu_addr;
                  we_r    <= cpu_we;
                  wdata_r <= cpu_wdata;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
                  if (!we_r) cpu_rdata <= data_mem[idx];
               end else if (miss_count != '1) begin
                  miss_count <= miss_count + CNT_W'(1);
               end
            end
            S_RD_WAIT: begin
               if (mem_rsp_valid) begin
                  valid_r[idx] <= 1'b1;
                  cpu_rdata    <= mem_rdata;
               end
            end
            S_WR_REQ: if (mem_req_ready) cpu_rdata <= wdata_r;
            S_FLUSH: begin
               valid_r[flush_cnt] <= 1'b0;
               flush_cnt          <= flush_cnt + INDEX_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Tag/data arrays carry no reset; only the valid bits qualify their contents.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == S_LOOKUP && we_r && hit) begin
            data_mem[idx] <= wdata_r;
         end else if (state == S_RD_WAIT && mem_rsp_valid) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_cache_wt_dm.sv
// Directed bench for cache_wt_dm: miss/hit, conflict, write-through,
// backpressure, flush, mid-operation reset and counter saturation.
module tb_cache_wt_dm;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req_valid, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_req_ready, cpu_rsp_valid;
   logic [31:0] cpu_rdata;
   logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        flush, flush_busy;
   logic [15:0] hit_count, miss_count;

   logic        s_req_ready, s_rsp_valid, s_mem_req_valid, s_mem_we, s_flush_busy;
   logic [31:0] s_cpu_rdata, s_mem_addr, s_mem_wdata;
   logic [3:0]  s_hit_count, s_miss_count;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   cache_wt_dm dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rdata(cpu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .flush(flush), .flush_busy(flush_busy),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   // Same stimulus, 4-bit counters, to observe saturation.
   cache_wt_dm #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(s_req_ready),
      .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rsp_valid(s_rsp_valid), .cpu_rdata(s_cpu_rdata),
      .mem_req_valid(s_mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .flush(flush), .flush_busy(s_flush_busy),
      .hit_count(s_hit_count), .miss_count(s_miss_count)
   );

   // Runs one CPU transaction with a zero-wait memory; lat counts cycles from acceptance edge.
   task automatic cpu_xact(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] mdata, output logic [31:0] rdata, output int lat,
                           output bit mseen, output logic [31:0] maddr, output logic [31:0] mwdata,
                           output bit mwe);
      bit rsent;
      rsent = 1'b0; mseen = 1'b0; lat = -1; rdata = 'x; maddr = '0; mwdata = '0; mwe = 1'b0;
      for (int w = 0; w < 10 && !cpu_req_ready; w++) begin
         @(posedge clk); #1;
      end
      cpu_req_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      @(posedge clk); #1;
      cpu_req_valid = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk); #1;
         mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
         if (cpu_rsp_valid) begin
            rdata = cpu_rdata; lat = k + 1;
            break;
         end
         if (mem_req_valid) begin
            if (!mseen) begin
               mseen = 1'b1; maddr = mem_addr; mwe = mem_we; mwdata = mem_wdata;
            end
            mem_req_ready = 1'b1;
         end else if (mseen && !rsent && !we) begin
            mem_rsp_valid = 1'b1; mem_rdata = mdata; rsent = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      vec_cnt++; if (cpu_req_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_req_ready: got %b want 1", cpu_req_ready); end
      vec_cnt++; if ({cpu_rsp_valid, mem_req_valid, mem_we, flush_busy} !== 4'b0) begin err_cnt++; $display("FAIL rst_strobes: got %b want 0000", {cpu_rsp_valid, mem_req_valid, mem_we, flush_busy}); end
      vec_cnt++; if ({cpu_rdata, mem_addr, mem_wdata} !== 96'h0) begin err_cnt++; $display("FAIL rst_data: got %h %h %h want 0", cpu_rdata, mem_addr, mem_wdata); end
      vec_cnt++; if ({hit_count, miss_count} !== 32'h0) begin err_cnt++; $display("FAIL rst_counters: got %0d %0d want 0 0", hit_count, miss_count); end
   endtask

   task automatic test_miss_hit();
      logic [31:0] rd, ma, mw; int lat; bit ms, mwe;
      cpu_xact(1'b0, 32'h0000_1004, '0, 32'hDEAD_BEEF, rd, lat, ms, ma, mw, mwe);
      vec_cnt++; if (!ms || ma !== 32'h0000_1004 || mwe !== 1'b0) begin err_cnt++; $display("FAIL miss_memreq: seen %b addr %h we %b want 1 00001004 0", ms, ma, mwe); end
      vec_cnt++; if (rd !== 32'hDEAD_BEEF || lat !== 4) begin err_cnt++; $display("FAIL miss_rsp: got %h lat %0d want deadbeef lat 4", rd, lat); end
      vec_cnt++; if (miss_count !== 16'd1) begin err_cnt++; $display("FAIL miss_count1: got %0d want 1", miss_count); end
      cpu_xact(1'b0, 32'h0000_1004, '0, 32'h0BAD_0BAD, rd, lat, ms, ma, mw, mwe);
      vec_cnt++; if (ms !== 1'b0 || lat !== 2 || rd !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL hit_rsp: mem %b lat %0d data %h want 0 2 deadbeef", ms, lat, rd); end
      vec_cnt++; if (hit_count !== 16'd1) begin err_cnt++; $display("FAIL hit_count1: got %0d want 1", hit_count); end
   endtask

   task automatic test_conflict();
      logic [31:0] rd, ma, mw; int lat; bit ms, mwe;
      cpu_xact(1'b0, 32'h0000_2004, '0, 32'hCAFE_0001, rd, lat, ms, ma, mw, mwe);
      vec_cnt++; if (ms !== 1'b1 || rd !== 32'hCAFE_0001) begin err_cnt++; $display("FAIL conflict_fill: mem %b data %h want 1 cafe0001", ms, rd); end
      cpu_xact(1'b0, 32'h0000_1004, '0, 32'hDEAD_BEEF, rd, lat, ms, ma, mw, mwe);
      vec_cnt++; if (ms !== 1'b1 || lat !== 4) begin err_cnt++; $display("FAIL conflict_remiss: mem %b lat %0d want 1 4", ms, lat); end
      vec_cnt++; if (miss_count !== 16'd3) begin err_cnt++; $display("FAIL miss_count3: got %0d want 3", miss_count); end
   endtask

   task automatic test_write_through();
      logic [31:0] rd, ma, mw; int lat; bit ms, mwe;
      cpu_xact(1'b1, 32'h0000_1004, 32'h1234_5678, '0, rd, lat, ms, ma, mw, mwe);
      vec_cnt++; if (!ms || mwe !== 1'b1 || ma !== 32'h0000_1004 || mw !== 32'h1234_5678) begin err_cnt++; $display("FAIL wr_hit_mem: seen %b we %b addr %h data %h", ms, mwe, ma, mw); end
      vec_cnt++; if (rd !== 32'h1234_5678 || lat !== 3 || hit_count !== 16'd2) begin err_cnt++; $display("FAIL wr_hit_rsp: data %h lat %0d hits %0d want 12345678 3 2", rd, lat, hit_count); end
      cpu_xact(1'b0, 32'h0000_1004, '0, 32'hFFFF_0000, rd, lat, ms, ma, mw, mwe);
      vec_cnt++; if (ms !== 1'b0 || rd !== 32'h1234_5678) begin err_cnt++; $display("FAIL wr_hit_readback: mem %b data %h want 0 12345678", ms, rd); end
      cpu_xact(1'b1, 32'h0000_3008, 32'hA5A5_A5A5, '0, rd, lat, ms, ma, mw, mwe);
      vec_cnt++; if (!ms || mwe !== 1'b1 || ma !== 32'h0000_3008 || miss_count !== 16'd4) begin err_cnt++; $display("FAIL wr_miss_mem: seen %b we %b addr %h misses %0d", ms, mwe, ma, miss_count); end
      cpu_xact(1'b0, 32'h0000_3008, '0, 32'hA5A5_A5A5, rd, lat, ms, ma, mw, mwe);
      vec_cnt++; if (ms !== 1'b1 || miss_count !== 16'd5) begin err_cnt++; $display("FAIL wr_miss_noalloc: mem %b misses %0d want 1 5", ms, miss_count); end
   endtask

   task automatic test_backpressure();
      int bad, rsps;
      bad = 0; rsps = 0;
      for (int w = 0; w < 10 && !cpu_req_ready; w++) begin
         @(posedge clk); #1;
      end
      cpu_req_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_4000; cpu_wdata = 32'h0BAD_F00D;
      @(posedge clk); #1 cpu_req_valid = 1'b0;
      @(posedge clk); #1;
      repeat (5) begin
         if (mem_req_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0000_4000 ||
             mem_wdata !== 32'h0BAD_F00D || cpu_req_ready !== 1'b0 || cpu_rsp_valid !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      vec_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL bp_stable: %0d unstable cycles want 0", bad); end
      mem_req_ready = 1'b1;
      @(posedge clk); #1 mem_req_ready = 1'b0;
      vec_cnt++; if (cpu_rsp_valid !== 1'b1 || cpu_rdata !== 32'h0BAD_F00D) begin err_cnt++; $display("FAIL bp_rsp: valid %b data %h want 1 0badf00d", cpu_rsp_valid, cpu_rdata); end
      repeat (5) begin
         @(posedge clk); #1;
         if (cpu_rsp_valid) rsps++;
      end
      vec_cnt++; if (rsps !== 0) begin err_cnt++; $display("FAIL bp_single_rsp: %0d extra responses want 0", rsps); end
   endtask

   task automatic test_flush();
      logic [31:0] rd, ma, mw; int lat, n; bit ms, mwe;
      logic [15:0] hits0, miss0;
      for (int w = 0; w < 10 && !cpu_req_ready; w++) begin
         @(posedge clk); #1;
      end
      hits0 = hit_count; miss0 = miss_count;
      flush = 1'b1; cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1004;
      #1;
      vec_cnt++; if (cpu_req_ready !== 1'b0) begin err_cnt++; $display("FAIL flush_blocks_req: ready %b want 0", cpu_req_ready); end
      @(posedge clk); #1 flush = 1'b0; cpu_req_valid = 1'b0;
      n = 0;
      while (flush_busy && n < 2000) begin
         n++;
         @(posedge clk); #1;
      end
      vec_cnt++; if (n !== 1024) begin err_cnt++; $display("FAIL flush_len: busy %0d cycles want 1024", n); end
      vec_cnt++; if (hit_count !== hits0 || miss_count !== miss0) begin err_cnt++; $display("FAIL flush_no_lookup: hits %0d misses %0d want %0d %0d", hit_count, miss_count, hits0, miss0); end
      cpu_xact(1'b0, 32'h0000_1004, '0, 32'h1234_5678, rd, lat, ms, ma, mw, mwe);
      vec_cnt++; if (ms !== 1'b1 || lat !== 4) begin err_cnt++; $display("FAIL flush_miss: mem %b lat %0d want 1 4", ms, lat); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, ma, mw; int lat, stray; bit ms, mwe;
      stray = 0;
      for (int w = 0; w < 10 && !cpu_req_ready; w++) begin
         @(posedge clk); #1;
      end
      cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_5000;
      @(posedge clk); #1 cpu_req_valid = 1'b0;
      @(posedge clk); #1 mem_req_ready = 1'b1;
      @(posedge clk); #1 mem_req_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      vec_cnt++; if (mem_req_valid !== 1'b0 || hit_count !== 16'd0 || miss_count !== 16'd0) begin err_cnt++; $display("FAIL rst_mid_clear: memreq %b hits %0d misses %0d want 0 0 0", mem_req_valid, hit_count, miss_count); end
      mem_rsp_valid = 1'b1; mem_rdata = 32'h7777_7777;
      @(posedge clk); #1 mem_rsp_valid = 1'b0;
      repeat (3) begin
         if (cpu_rsp_valid) stray++;
         @(posedge clk); #1;
      end
      vec_cnt++; if (stray !== 0) begin err_cnt++; $display("FAIL rst_late_rsp: %0d responses want 0", stray); end
      cpu_xact(1'b0, 32'h0000_1004, '0, 32'h1234_5678, rd, lat, ms, ma, mw, mwe);
      vec_cnt++; if (ms !== 1'b1 || miss_count !== 16'd1) begin err_cnt++; $display("FAIL rst_lines_invalid: mem %b misses %0d want 1 1", ms, miss_count); end
   endtask

   task automatic test_saturation();
      logic [31:0] rd, ma, mw; int lat; bit ms, mwe;
      repeat (20) cpu_xact(1'b0, 32'h0000_1004, '0, '0, rd, lat, ms, ma, mw, mwe);
      vec_cnt++; if (rd !== 32'h1234_5678 || ms !== 1'b0) begin err_cnt++; $display("FAIL sat_last_hit: data %h mem %b want 12345678 0", rd, ms); end
      vec_cnt++; if (hit_count !== 16'd20) begin err_cnt++; $display("FAIL sat_wide: got %0d want 20", hit_count); end
      vec_cnt++; if (s_hit_count !== 4'd15) begin err_cnt++; $display("FAIL sat_narrow: got %0d want 15", s_hit_count); end
   endtask

   initial begin
      test_reset();
      test_miss_hit();
      test_conflict();
      test_write_through();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
